css_mcu0_el2_dec_gpr_mp_ctl: RTL



---
 rtl/css_mcu0_el2_dec_gpr_mp_ctl.sv | 107 ++++++++++
 1 files changed

// File: rtl/css_mcu0_el2_dec_gpr_mp_ctl.sv
// Multi-port decode GPR file: priority-resolved writes, collision flags and a pending scoreboard.
// Optional macro RV_GPR_WR_BYPASS_EN adds same-cycle write-to-read forwarding.
module css_mcu0_el2_dec_gpr_mp_ctl #(
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 3,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int LL_PORT  = NUM_WR - 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*AW-1:0]     waddr,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  output logic [NUM_REGS-1:0]      sb_busy,
  output logic                     wr_collision,
  output logic                     collision_err
);

  logic [DATA_W-1:0]   regs    [NUM_REGS];
  logic [DATA_W-1:0]   wr_data [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] ll_hit;
  logic [NUM_REGS-1:0] busy;
  logic                coll_next;
  logic                sb_hit;

  // Per-register write resolution; the first matching port in index order wins the data.
  always_comb begin
    wr_hit    = '0;
    ll_hit    = '0;
    coll_next = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wr_data[r] = '0;
    end
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (r != 0 && wen[p] && waddr[p*AW +: AW] == AW'(r)) begin
          if (wr_hit[r]) begin
            coll_next = 1'b1;
          end else begin
            wr_hit[r]  = 1'b1;
            wr_data[r] = wd[p*DATA_W +: DATA_W];
          end
          if (p == LL_PORT) begin
            ll_hit[r] = 1'b1;
          end
        end
      end
    end
  end

  assign sb_hit = sb_set && (sb_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
      busy          <= '0;
      wr_collision  <= 1'b0;
      collision_err <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_data[r];
        end
        // A new long-latency issue supersedes a same-cycle completion.
        if (sb_hit && sb_addr == AW'(r)) begin
          busy[r] <= 1'b1;
        end else if (ll_hit[r]) begin
          busy[r] <= 1'b0;
        end
      end
      wr_collision  <= coll_next;
      collision_err <= collision_err | coll_next;
    end
  end

  assign sb_busy = busy;

  always_comb begin
    rd      = '0;
    rd_pend = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd[i*DATA_W +: DATA_W] = regs[raddr[i*AW +: AW]];
      rd_pend[i]             = busy[raddr[i*AW +: AW]];
`ifdef RV_GPR_WR_BYPASS_EN
      // Walk ports from lowest priority upward so the highest-priority match is left standing.
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (raddr[i*AW +: AW] != '0 && wen[NUM_WR-1-k] &&
            waddr[(NUM_WR-1-k)*AW +: AW] == raddr[i*AW +: AW]) begin
          rd[i*DATA_W +: DATA_W] = wd[(NUM_WR-1-k)*DATA_W +: DATA_W];
          rd_pend[i]             = (NUM_WR-1-k == LL_PORT) ? 1'b0 : busy[raddr[i*AW +: AW]];
        end
      end
`endif
    end
  end

endmodule
